nand_sweep_checker: RTL and testbench

Sequential stimulus-and-check stage wrapped around a 2-input NAND gate. On a start request it drives every `(a, b)` combination into the gate. It waits a programmable settle time, samples the gate output `y` and compares it against the expected NAND result. It accumulates error information over several full sweeps and reports pass/fail with a start/done handshake. It sits upstream of the gate (feeds `a`, `b`) and downstream of it (consumes `y`).

---
 rtl/nand_sweep_checker.sv | 127 ++++++++++++
 tb/tb_nand_sweep_checker.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/nand_sweep_checker.sv
// Exhaustive NAND checker: sweeps {a,b} = 00..11 PASSES times,
// samples y after SETTLE cycles and accumulates mismatch info.
module nand_sweep_checker #(
   parameter int SETTLE = 2,
   parameter int PASSES = 4,
   parameter int ERR_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             y,
   output logic             a,
   output logic             b,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [3:0]       fail_vec
);

   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
   localparam logic [SW-1:0] SLAST = SW'(SETTLE - 1);
   localparam logic [PW-1:0] PLAST = PW'(PASSES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRIVE,
      S_SAMPLE,
      S_DONE
   } state_t;

   state_t           r_state;
   logic [1:0]       r_vec;
   logic [SW-1:0]    r_scnt;
   logic [PW-1:0]    r_pcnt;
   logic             r_a;
   logic             r_b;
   logic             r_busy;
   logic             r_done;
   logic             r_pass;
   logic [ERR_W-1:0] r_err;
   logic [3:0]       r_fail;

   logic             w_mis;
   logic [ERR_W-1:0] w_err_nx;
   logic [1:0]       w_vec_nx;

   assign w_mis    = (y != ~(r_a & r_b));
   assign w_err_nx = (w_mis && (r_err != '1)) ? r_err + ERR_W'(1) : r_err;
   assign w_vec_nx = r_vec + 2'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_vec   <= '0;
         r_scnt  <= '0;
         r_pcnt  <= '0;
         r_a     <= 1'b0;
         r_b     <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_pass  <= 1'b0;
         r_err   <= '0;
         r_fail  <= '0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               r_a    <= 1'b0;
               r_b    <= 1'b0;
               r_busy <= 1'b0;
               if (start) begin
                  r_state <= S_DRIVE;
                  r_vec   <= '0;
                  r_scnt  <= '0;
                  r_pcnt  <= '0;
                  r_err   <= '0;
                  r_fail  <= '0;
                  r_pass  <= 1'b0;
                  r_busy  <= 1'b1;
               end
            end
            S_DRIVE: begin
               if (r_scnt == SLAST) r_state <= S_SAMPLE;
               else r_scnt <= r_scnt + SW'(1);
            end
            S_SAMPLE: begin
               r_err  <= w_err_nx;
               r_scnt <= '0;
               if (w_mis) r_fail[r_vec] <= 1'b1;
               if (r_vec != 2'd3) begin
                  r_vec   <= w_vec_nx;
                  r_a     <= w_vec_nx[1];
                  r_b     <= w_vec_nx[0];
                  r_state <= S_DRIVE;
               end else if (r_pcnt != PLAST) begin
                  r_vec   <= '0;
                  r_pcnt  <= r_pcnt + PW'(1);
                  r_a     <= 1'b0;
                  r_b     <= 1'b0;
                  r_state <= S_DRIVE;
               end else begin
                  // pass must see the final compare, so use the next count
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                  r_pass  <= (w_err_nx == '0);
                  r_busy  <= 1'b0;
                  r_a     <= 1'b0;
                  r_b     <= 1'b0;
               end
            end
            S_DONE: r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign a         = r_a;
   assign b         = r_b;
   assign busy      = r_busy;
   assign done      = r_done;
   assign pass      = r_pass;
   assign err_count = r_err;
   assign fail_vec  = r_fail;

endmodule

// File: tb/tb_nand_sweep_checker.sv
// Directed bench for nand_sweep_checker: good, stuck-at and inverted
// gates, back-to-back starts, mid-run reset, counter saturation.
module tb_nand_sweep_checker;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start0 = 1'b0;
   logic       start1 = 1'b0;
   logic [1:0] mode = 2'd0;
   logic       y0, a0, b0, busy0, done0, pass0;
   logic       y1, a1, b1, busy1, done1, pass1;
   logic [7:0] err0;
   logic [1:0] err1;
   logic [3:0] fail0, fail1;
   int         n_cmp = 0;
   int         n_bad = 0;
   logic       seen;

   always #5 clk = ~clk;

   // mode 0: real NAND, 1: y stuck at 1, 2: y stuck at 0
   assign y0 = (mode == 2'd0) ? ~(a0 & b0) : (mode == 2'd1);
   assign y1 = a1 & b1;

   nand_sweep_checker u0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .y(y0),
      .a(a0), .b(b0), .busy(busy0), .done(done0), .pass(pass0),
      .err_count(err0), .fail_vec(fail0)
   );

   nand_sweep_checker #(.ERR_W(2)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .y(y1),
      .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
      .err_count(err1), .fail_vec(fail1)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic adv(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic pulse0;
      start0 = 1'b1;
      adv(1);
      start0 = 1'b0;
   endtask

   initial begin
      #12;
      chk("rst_a", a0, 0);
      chk("rst_busy", busy0, 0);
      chk("rst_done", done0, 0);
      chk("rst_pass", pass0, 0);
      chk("rst_err", err0, 0);
      chk("rst_fail", fail0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      adv(1);

      // good gate
      mode = 2'd0;
      pulse0;
      chk("r1_busy_e0", busy0, 1);
      chk("r1_ab0", {a0, b0}, 2'b00);
      adv(3);
      chk("r1_ab1", {a0, b0}, 2'b01);
      adv(3);
      chk("r1_ab2", {a0, b0}, 2'b10);
      adv(3);
      chk("r1_ab3", {a0, b0}, 2'b11);
      adv(38);
      chk("r1_busy47", busy0, 1);
      chk("r1_done47", done0, 0);
      adv(1);
      chk("r1_done48", done0, 1);
      chk("r1_busy48", busy0, 0);
      chk("r1_pass", pass0, 1);
      chk("r1_err", err0, 0);
      chk("r1_fail", fail0, 4'b0000);
      chk("r1_ab_done", {a0, b0}, 2'b00);
      adv(1);
      chk("r1_done49", done0, 0);
      chk("r1_busy49", busy0, 0);
      chk("r1_pass_hold", pass0, 1);

      // y stuck at 1
      mode = 2'd1;
      pulse0;
      adv(48);
      chk("s1_done", done0, 1);
      chk("s1_err", err0, 4);
      chk("s1_fail", fail0, 4'b1000);
      chk("s1_pass", pass0, 0);
      adv(1);
      chk("s1_err_hold", err0, 4);

      // y stuck at 0, start held through two runs
      mode = 2'd2;
      start0 = 1'b1;
      adv(1);
      chk("h_busy_e0", busy0, 1);
      chk("h_pass_clr", pass0, 0);
      adv(48);
      chk("h_done48", done0, 1);
      chk("h_err", err0, 12);
      chk("h_fail", fail0, 4'b0111);
      chk("h_pass", pass0, 0);
      adv(1);
      chk("h_done49", done0, 0);
      chk("h_busy49", busy0, 0);
      chk("h_err49", err0, 12);
      mode = 2'd0;
      adv(1);
      chk("h_busy50", busy0, 1);
      chk("h_err50", err0, 0);
      chk("h_fail50", fail0, 0);
      adv(47);
      chk("h_done97", done0, 0);
      adv(1);
      chk("h_done98", done0, 1);
      chk("h_pass2", pass0, 1);
      start0 = 1'b0;
      adv(2);
      chk("h_busy_end", busy0, 0);
      chk("h_done_end", done0, 0);

      // reset in the middle of a run
      pulse0;
      adv(20);
      chk("m_busy20", busy0, 1);
      rst_n = 1'b0;
      #1;
      chk("m_a", a0, 0);
      chk("m_busy", busy0, 0);
      chk("m_done", done0, 0);
      chk("m_fail", fail0, 0);
      adv(1);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         adv(1);
         seen = seen | done0;
      end
      chk("m_no_done", seen, 0);
      chk("m_idle", busy0, 0);
      pulse0;
      adv(48);
      chk("m_done48", done0, 1);
      chk("m_pass", pass0, 1);
      chk("m_err", err0, 0);

      // inverted gate on a 2-bit counter
      start1 = 1'b1;
      adv(1);
      start1 = 1'b0;
      chk("x_busy", busy1, 1);
      adv(48);
      chk("x_done", done1, 1);
      chk("x_err", err1, 3);
      chk("x_fail", fail1, 4'b1111);
      chk("x_pass", pass1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
